mul_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply group: MUL, MULH, MULHSU and MULHU.
- Drives one shared instance of the team's combinational `multiplier`, which computes a 32x32 product and keeps only the low 32 bits.
- Each high-half product is built as four 16x16 partial products with a 64-bit accumulator, computed on operand magnitudes with a final sign fix.
- Sits between the EX-stage issue logic and writeback through valid/ready handshakes.

---
 rtl/mul_seq_pkg.sv | 26 ++
 rtl/mul_seq_multiplier.sv | 13 +
 rtl/mul_seq.sv | 181 ++++++++++++++++++
 tb/tb_mul_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Package shared by the RV32M multiply sequencer and its decoder.
// Provides:
//   - OP_* localparams : 2-bit multiply-group op codes (funct3[1:0] style)
//   - state_e          : sequencer FSM encoding (also exported for debug)
//   - mag_of()         : two's-complement magnitude helper
package mul_seq_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Magnitude of a 32-bit value when it is to be treated as negative.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mul_seq_multiplier.sv
// Shared combinational multiplier: 32x32 product, low 32 bits only.
// Ports:
//   a_i, b_i : 32-bit unsigned operands
//   p_o      : (a_i * b_i) mod 2^32
module multiplier (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle sequencer for MUL / MULH / MULHSU / MULHU.
// Drives one low-word multiplier; high-half products are assembled from four
// 16x16 partial products on operand magnitudes, then sign-corrected.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous cancel of any in-flight operation
//   req_valid/req_ready   : request handshake; req_op/req_a/req_b payload
//   resp_valid/resp_ready : response handshake; resp_result payload
//   dbg_state             : current FSM state, for observation only
//
// Handshake rules: a transfer happens on a rising edge where valid & ready
// are both high. req_ready is high only in IDLE without flush. resp_valid is
// high only in DONE, and resp_result is stable while resp_valid is high and
// resp_ready is low. A request is accepted only after the previous response
// has been consumed (no overlap).
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter bit MUL_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] result_q, result_d;

  logic [31:0] mult_a, mult_b, mult_p;
  logic        sa, sb;
  logic        fast_path;
  logic [63:0] final_val;
  logic [63:0] pp_shifted;

  multiplier u_mult (
    .a_i (mult_a),
    .b_i (mult_b),
    .p_o (mult_p)
  );

  // Request-side sign decode; only meaningful at acceptance.
  assign sa = req_a[31] & ((req_op == OP_MULH) | (req_op == OP_MULHSU));
  assign sb = req_b[31] & (req_op == OP_MULH);

  // For MUL no operand is signed, so the latched magnitudes equal the raw
  // operands and can feed the full-width pass directly.
  assign fast_path = MUL_FAST && (op_q == OP_MUL);

  assign final_val = neg_q ? (64'd0 - acc_q) : acc_q;

  assign req_ready   = (state_q == ST_IDLE) & ~flush;
  assign resp_valid  = (state_q == ST_DONE);
  assign resp_result = result_q;
  assign dbg_state   = state_q;

  // Multiplier operands: zero outside CALC so the array does not toggle.
  always_comb begin
    mult_a = 32'd0;
    mult_b = 32'd0;
    if (state_q == ST_CALC) begin
      if (fast_path) begin
        mult_a = ma_q;
        mult_b = mb_q;
      end else begin
        case (step_q)
          2'd0: begin mult_a = {16'd0, ma_q[15:0]};  mult_b = {16'd0, mb_q[15:0]};  end
          2'd1: begin mult_a = {16'd0, ma_q[15:0]};  mult_b = {16'd0, mb_q[31:16]}; end
          2'd2: begin mult_a = {16'd0, ma_q[31:16]}; mult_b = {16'd0, mb_q[15:0]};  end
          default: begin mult_a = {16'd0, ma_q[31:16]}; mult_b = {16'd0, mb_q[31:16]}; end
        endcase
      end
    end
  end

  // Partial product aligned to its weight for the current step.
  always_comb begin
    pp_shifted = 64'd0;
    case (step_q)
      2'd0:    pp_shifted = {32'd0, mult_p};
      2'd1,
      2'd2:    pp_shifted = {16'd0, mult_p, 16'd0};
      default: pp_shifted = {mult_p, 32'd0};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          ma_d    = mag_of(req_a, sa);
          mb_d    = mag_of(req_b, sb);
          neg_d   = sa ^ sb;
          acc_d   = 64'd0;
          step_d  = 2'd0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (fast_path) begin
          result_d = mult_p;
          state_d  = ST_DONE;
        end else begin
          // Magnitudes are < 2^32 each, so the 64-bit sum never overflows.
          acc_d  = acc_q + pp_shifted;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        result_d = (op_q == OP_MUL) ? final_val[31:0] : final_val[63:32];
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything; a response handshaking this cycle is
    // treated as consumed since DONE->IDLE is the same move.
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      step_q   <= 2'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: one MUL_FAST=1 and one MUL_FAST=0 instance share the
// request/response wires; 'sel' picks which one is active and observed.
module tb_mul_seq;
  import mul_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        sel = 1'b0;

  logic        rr_f, rv_f, rr_s, rv_s;
  logic [31:0] res_f, res_s;
  state_e      st_f, st_s;

  logic        req_ready, resp_valid;
  logic [31:0] resp_result;
  state_e      st;

  mul_seq #(.MUL_FAST(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid & ~sel), .req_ready(rr_f),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(rv_f), .resp_ready(resp_ready & ~sel),
    .resp_result(res_f), .dbg_state(st_f)
  );

  mul_seq #(.MUL_FAST(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid & sel), .req_ready(rr_s),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(rv_s), .resp_ready(resp_ready & sel),
    .resp_result(res_s), .dbg_state(st_s)
  );

  assign req_ready   = sel ? rr_s  : rr_f;
  assign resp_valid  = sel ? rv_s  : rv_f;
  assign resp_result = sel ? res_s : res_f;
  assign st          = sel ? st_s  : st_f;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // Reference: extend each operand per the op's signedness, multiply in
  // 64 bits, pick the requested half.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // ---------------- driver ----------------
  // Issues one op, checks latency, result, stability under backpressure
  // for bp cycles, then the handshake and req_ready return.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int bp);
    int n;
    int lat;
    logic [31:0] want;
    exp_q.push_back(exp);
    lat = (op == OP_MUL && !sel) ? 1 : 5;
    @(negedge clk);
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 2'($urandom_range(0, 3));
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    want = exp_q.pop_front();
    check_eq("latency", 32'(n), 32'(lat));
    check_eq("result", resp_result, want);
    check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_eq("bp_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("bp_result", resp_result, want);
      check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check_eq("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("post_hs_valid", {31'd0, resp_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_result", resp_result, 32'd0);
    check_eq("rst_state", 32'(st), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Directed cases on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
      run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
      run_op(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 0);
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(OP_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 3);
      run_op(OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0, ref_mul(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0), 0);
    end

    // Flush during CALC step2 of MULHU.
    sel = 1'b1;
    @(negedge clk);
    req_op = OP_MULHU; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_state", 32'(st), 32'(ST_IDLE));
    check_eq("flush_req_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("flush_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_op(OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 0);

    // Flush together with req_valid in IDLE: not accepted.
    @(negedge clk);
    req_op = OP_MULH; req_valid = 1'b1; flush = 1'b1;
    #1 check_eq("flush_idle_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check_eq("flush_idle_state", 32'(st), 32'(ST_IDLE));

    // Asynchronous reset mid-CALC.
    sel = 1'b1;
    @(negedge clk);
    req_op = OP_MULH; req_a = 32'h1357_9BDF; req_b = 32'h8642_0ECA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("arst_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("arst_result", resp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("arst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_op(OP_MULH, 32'h1357_9BDF, 32'h8642_0ECA, ref_mul(OP_MULH, 32'h1357_9BDF, 32'h8642_0ECA), 1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      run_op(op, a, b, ref_mul(op, a, b), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
